rx_comma_phase_ctrl: RTL and testbench
======================================

# rx_comma_phase_ctrl

Comma-based phase-lock controller for the 20b-to-10b RX unpacker in the 1G Ethernet receive path. It watches the raw 20b transceiver words for K28.5 in the upper or lower 10b half. It decides which half carries code-group alignment and drives the unpacker's `align_event` and `prefer_upper_first` controls. It also tracks lock, with loss-of-sync detection and automatic re-acquisition.

## Interface
Parameters:
- `ACQ_COMMAS`, 3: consecutive same-half commas needed to declare lock (1..255).
- `GOOD_COMMAS`, 4: consecutive correct-half commas that clear the error count (1..255).
- `ERR_MAX`, 4: misaligned-comma errors that drop lock (1..255).
- `COMMA_WINDOW`, 64: maximum number of valid words without a correct-half comma before falling to LOS (1..65535).
- `COMMA_NEG`, 10'h0FA: K28.5 RD- pattern.
- `COMMA_POS`, 10'h305: K28.5 RD+ pattern.

Ports:
- `clk`  in  1: RXUSRCLK2, single clock.
- `rst`  in  1: synchronous, active-high reset.
- `rwenb`  in  20: raw transceiver word, {upper[19:10], lower[9:0]}.
- `rwenb_valid`  in  1: `rwenb` is a fresh word.
- `align_event`  out  1: one-cycle pulse to the unpacker on each lock acquisition.
- `prefer_upper_first`  out  1: 1 = the aligned comma is in the upper half.
- `locked`  out  1: high while in SYNC.
- `relock_cnt`  out  8: saturating count of SYNC→LOS transitions.

## Operation
- Comma hit per half: `hit_u` = (upper == COMMA_NEG or upper == COMMA_POS); `hit_l` is the same test on lower.
- `cand` is a 1-bit register; 1 = upper.
- "Correct comma" means the candidate half hits: (`cand` ? `hit_u` : `hit_l`).
- "Wrong comma" means only the other half hits.
- Words with `rwenb_valid`=0 are ignored; all state and counters hold.
- States:
  - LOS:
    - Valid word with `hit_u` → `cand`=1, `good_cnt`=1, go to ACQ.
    - Else with `hit_l` → `cand`=0, `good_cnt`=1, go to ACQ.
    - If both halves hit, upper wins.
    - `locked`=0.
  - ACQ:
    - Correct comma → `good_cnt`+1 and `win_cnt`=0.
    - When `good_cnt`+1 == ACQ_COMMAS → go to SYNC, pulse `align_event`, set `prefer_upper_first`=`cand`, set `locked`=1, clear `err_cnt`/`good_cnt`.
    - Wrong comma → restart the candidate on the other half, `good_cnt`=1.
    - No comma → `win_cnt`+1; if `win_cnt` reaches COMMA_WINDOW → LOS.
  - SYNC:
    - Correct comma → `win_cnt`=0 and `good_cnt`+1.
    - When `good_cnt` reaches GOOD_COMMAS → `err_cnt`=0, `good_cnt`=0.
    - Wrong comma → `err_cnt`+1, `good_cnt`=0; if `err_cnt`+1 == ERR_MAX → LOS.
    - No comma → `win_cnt`+1; if it reaches COMMA_WINDOW → LOS.
    - Every SYNC→LOS transition increments `relock_cnt` (saturates at 255) and clears `locked`.
- ACQ_COMMAS=1 → a single comma from LOS goes straight to SYNC; LOS→ACQ is skipped.
- `prefer_upper_first` holds its last value outside acquisition.
- Counter widths: `good_cnt`/`err_cnt` 8b, `win_cnt` 16b. No counter ever wraps; they are compared with ==.

## Timing
- All outputs are registered.
- Reset values: `align_event`=0, `prefer_upper_first`=1, `locked`=0, `relock_cnt`=0. Reset state is LOS with all counters 0.
- Completing word accepted at edge N → `align_event`=1, the new `prefer_upper_first`, and `locked`=1 are all visible after edge N+1. `align_event` is high for exactly one cycle.
- Loss is visible on `locked` one cycle after the offending word.
- No re-pulse occurs while in SYNC.
- `rst` mid-operation → state returns to reset values at the next edge and any pending pulse is dropped. Reset dominates over a simultaneous valid word.

## Configuration
- `RX_PHASE_STATS_EN` defined: the `relock_cnt` counter is implemented as described.
- `RX_PHASE_STATS_EN` undefined: `relock_cnt` is tied to 8'd0 and no counter logic exists. All other behaviour is identical.

## Test plan
- Reset, then 3 valid words with upper = 10'h0FA and lower = 10'h000 → a single `align_event` pulse after the 3rd word; `prefer_upper_first`=1, `locked`=1.
- 3 valid words with lower = 10'h305 and upper = 10'h2AA, with idle cycles (`rwenb_valid`=0) between them → lock with `prefer_upper_first`=0; idle cycles do not affect counts.
- Locked on lower, then 4 words carrying a comma only in upper → `locked` falls after the 4th; `relock_cnt`=1 (0 with `RX_PHASE_STATS_EN` undefined).
- Locked, 3 wrong commas, then 4 correct, then 3 wrong → stays locked; the error count is cleared in between.
- Locked, then 64 valid non-comma words → `locked` falls after the 64th; 63 words followed by a correct comma keeps lock.
- ACQ with 2 upper commas, then 1 lower-only comma, then 2 more lower commas → lock with `prefer_upper_first`=0 after the 5th word; `rst` asserted during ACQ → LOS with no pulse.

Source files
------------

// File: rtl/rx_comma_phase_ctrl.sv
// rx_comma_phase_ctrl
//
// Comma-based phase-lock controller for the 20b-to-10b RX unpacker (1G Ethernet).
// It scans each raw 20b transceiver word for K28.5 (either running disparity)
// in the upper and the lower 10b half. It picks the half that carries code-group
// alignment, drives the unpacker's align_event / prefer_upper_first controls,
// and tracks lock. Lock is dropped on misaligned commas or on comma starvation,
// and is re-acquired automatically.
//
// Ports:
//   clk                 in   1  RXUSRCLK2, single clock domain
//   rst                 in   1  synchronous, active-high reset
//   rwenb               in  20  raw transceiver word {upper[19:10], lower[9:0]}
//   rwenb_valid         in   1  rwenb carries a fresh word this cycle
//   align_event         out  1  one-cycle pulse on each lock acquisition
//   prefer_upper_first  out  1  1 = aligned comma sits in the upper half
//   locked              out  1  high while in SYNC
//   relock_cnt          out  8  saturating count of SYNC->LOS transitions
//
// Configuration macro:
//   RX_PHASE_STATS_EN   defined: relock_cnt counter is built.
//                       undefined: relock_cnt is tied to 8'd0.
//
// Handshake: a word is consumed on every rising edge where rwenb_valid is high.
// There is no backpressure. When rwenb_valid is low, all state and counters hold.
//
// Latency: state and counters update on the edge that accepts a word. The
// outputs are registered from that state one edge later.

module rx_comma_phase_ctrl #(
    parameter int          ACQ_COMMAS   = 3,
    parameter int          GOOD_COMMAS  = 4,
    parameter int          ERR_MAX      = 4,
    parameter int          COMMA_WINDOW = 64,
    parameter logic [9:0]  COMMA_NEG    = 10'h0FA,
    parameter logic [9:0]  COMMA_POS    = 10'h305
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] rwenb,
    input  logic        rwenb_valid,
    output logic        align_event,
    output logic        prefer_upper_first,
    output logic        locked,
    output logic [7:0]  relock_cnt
);

    localparam logic [7:0]  ACQ_C  = 8'(ACQ_COMMAS);
    localparam logic [7:0]  GOOD_C = 8'(GOOD_COMMAS);
    localparam logic [7:0]  ERR_C  = 8'(ERR_MAX);
    localparam logic [15:0] WIN_C  = 16'(COMMA_WINDOW);

    typedef enum logic [1:0] {
        ST_LOS  = 2'd0,
        ST_ACQ  = 2'd1,
        ST_SYNC = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        cand_q, cand_d;
    logic [7:0]  good_q, good_d;
    logic [7:0]  err_q, err_d;
    logic [15:0] win_q, win_d;
    logic        lock_pulse_q, lock_pulse_d;

    logic        hit_u, hit_l;
    logic        correct_comma, wrong_comma;
    logic [7:0]  good_inc, err_inc;
    logic [15:0] win_inc;

    assign hit_u = (rwenb[19:10] == COMMA_NEG) || (rwenb[19:10] == COMMA_POS);
    assign hit_l = (rwenb[9:0]   == COMMA_NEG) || (rwenb[9:0]   == COMMA_POS);

    // A word with commas in both halves counts as correct because the
    // candidate half hits. "Wrong" means only the opposite half hits.
    assign correct_comma = cand_q ? hit_u : hit_l;
    assign wrong_comma   = cand_q ? (hit_l && !hit_u) : (hit_u && !hit_l);

    assign good_inc = good_q + 8'd1;
    assign err_inc  = err_q + 8'd1;
    assign win_inc  = win_q + 16'd1;

    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        good_d       = good_q;
        err_d        = err_q;
        win_d        = win_q;
        lock_pulse_d = 1'b0;

        if (rwenb_valid) begin
            case (state_q)
                ST_LOS: begin
                    if (hit_u || hit_l) begin
                        // Upper wins when both halves carry a comma.
                        cand_d = hit_u;
                        err_d  = 8'd0;
                        win_d  = 16'd0;
                        if (ACQ_C == 8'd1) begin
                            state_d      = ST_SYNC;
                            good_d       = 8'd0;
                            lock_pulse_d = 1'b1;
                        end else begin
                            state_d = ST_ACQ;
                            good_d  = 8'd1;
                        end
                    end
                end

                ST_ACQ: begin
                    if (correct_comma) begin
                        win_d = 16'd0;
                        if (good_inc == ACQ_C) begin
                            state_d      = ST_SYNC;
                            good_d       = 8'd0;
                            err_d        = 8'd0;
                            lock_pulse_d = 1'b1;
                        end else begin
                            good_d = good_inc;
                        end
                    end else if (wrong_comma) begin
                        // Restart the acquisition on the half that just hit.
                        cand_d = !cand_q;
                        good_d = 8'd1;
                        win_d  = 16'd0;
                    end else if (win_inc == WIN_C) begin
                        state_d = ST_LOS;
                        good_d  = 8'd0;
                        err_d   = 8'd0;
                        win_d   = 16'd0;
                    end else begin
                        win_d = win_inc;
                    end
                end

                ST_SYNC: begin
                    if (correct_comma) begin
                        win_d = 16'd0;
                        if (good_inc == GOOD_C) begin
                            good_d = 8'd0;
                            err_d  = 8'd0;
                        end else begin
                            good_d = good_inc;
                        end
                    end else begin
                        // A wrong comma is also a word without a correct-half
                        // comma, so it advances the starvation window as well.
                        if ((wrong_comma && (err_inc == ERR_C)) || (win_inc == WIN_C)) begin
                            state_d = ST_LOS;
                            good_d  = 8'd0;
                            err_d   = 8'd0;
                            win_d   = 16'd0;
                        end else begin
                            win_d = win_inc;
                            if (wrong_comma) begin
                                err_d  = err_inc;
                                good_d = 8'd0;
                            end
                        end
                    end
                end

                default: begin
                    state_d = ST_LOS;
                    good_d  = 8'd0;
                    err_d   = 8'd0;
                    win_d   = 16'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= ST_LOS;
            cand_q             <= 1'b1;
            good_q             <= 8'd0;
            err_q              <= 8'd0;
            win_q              <= 16'd0;
            lock_pulse_q       <= 1'b0;
            align_event        <= 1'b0;
            prefer_upper_first <= 1'b1;
            locked             <= 1'b0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            good_q       <= good_d;
            err_q        <= err_d;
            win_q        <= win_d;
            lock_pulse_q <= lock_pulse_d;
            align_event  <= lock_pulse_q;
            // cand_q cannot change while in SYNC, so it is still the locked
            // half one edge after the acquisition.
            if (lock_pulse_q) begin
                prefer_upper_first <= cand_q;
            end
            locked <= (state_q == ST_SYNC);
        end
    end

`ifdef RX_PHASE_STATS_EN
    logic       loss_q;
    logic [7:0] relock_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            loss_q   <= 1'b0;
            relock_q <= 8'd0;
        end else begin
            loss_q <= (state_q == ST_SYNC) && (state_d == ST_LOS);
            if (loss_q && (relock_q != 8'hFF)) begin
                relock_q <= relock_q + 8'd1;
            end
        end
    end

    assign relock_cnt = relock_q;
`else
    assign relock_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_rx_comma_phase_ctrl.sv
// Testbench for rx_comma_phase_ctrl: a directed vector table for the basic
// lock / loss flow, followed by hand-written multi-cycle sequences.
module tb_rx_comma_phase_ctrl;

    localparam logic [9:0] CN = 10'h0FA;  // K28.5 RD-
    localparam logic [9:0] CP = 10'h305;  // K28.5 RD+
    localparam logic [9:0] DZ = 10'h000;
    localparam logic [9:0] DA = 10'h2AA;

`ifdef RX_PHASE_STATS_EN
    localparam logic [7:0] RL1 = 8'd1;
`else
    localparam logic [7:0] RL1 = 8'd0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] rwenb = 20'd0;
    logic        rwenb_valid = 1'b0;

    logic        align_event, prefer_upper_first, locked;
    logic [7:0]  relock_cnt;
    logic        align1, prefer1, locked1;
    logic [7:0]  relock1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rx_comma_phase_ctrl u_dut (
        .clk(clk), .rst(rst), .rwenb(rwenb), .rwenb_valid(rwenb_valid),
        .align_event(align_event), .prefer_upper_first(prefer_upper_first),
        .locked(locked), .relock_cnt(relock_cnt)
    );

    // Single-comma acquisition variant, fed the same stimulus.
    rx_comma_phase_ctrl #(.ACQ_COMMAS(1)) u_dut1 (
        .clk(clk), .rst(rst), .rwenb(rwenb), .rwenb_valid(rwenb_valid),
        .align_event(align1), .prefer_upper_first(prefer1),
        .locked(locked1), .relock_cnt(relock1)
    );

    typedef struct {
        logic       r;
        logic       v;
        logic [9:0] u;
        logic [9:0] l;
        logic       e_align;
        logic       e_prefer;
        logic       e_locked;
        logic [7:0] e_relock;
    } vec_t;

    vec_t vq[$];

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic r, input logic v, input logic [9:0] u, input logic [9:0] l);
        rst = r;
        rwenb_valid = v;
        rwenb = {u, l};
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, DZ, DZ);
    endtask

    task automatic lock_lower(input string tag);
        step(1'b1, 1'b0, DZ, DZ);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, DA, CP);
        idle(2);
        chk({tag, " pre locked"}, locked, 1);
        chk({tag, " pre prefer"}, prefer_upper_first, 0);
    endtask

    initial begin
        // Each row: inputs for this edge, then outputs expected just after it.
        vq.push_back('{1, 0, DZ, DZ, 0, 1, 0, 0});  // reset
        vq.push_back('{0, 1, CN, DZ, 0, 1, 0, 0});  // LOS -> ACQ on upper
        vq.push_back('{0, 1, CN, DZ, 0, 1, 0, 0});
        vq.push_back('{0, 1, CN, DZ, 0, 1, 0, 0});  // third comma -> SYNC
        vq.push_back('{0, 0, DZ, DZ, 1, 1, 1, 0});  // pulse visible
        vq.push_back('{0, 0, DZ, DZ, 0, 1, 1, 0});  // pulse is one cycle
        vq.push_back('{1, 0, DZ, DZ, 0, 1, 0, 0});  // reset
        vq.push_back('{0, 1, DA, CP, 0, 1, 0, 0});  // ACQ on lower
        vq.push_back('{0, 0, DZ, DZ, 0, 1, 0, 0});
        vq.push_back('{0, 1, DA, CP, 0, 1, 0, 0});
        vq.push_back('{0, 0, DZ, DZ, 0, 1, 0, 0});
        vq.push_back('{0, 0, DZ, DZ, 0, 1, 0, 0});
        vq.push_back('{0, 1, DA, CP, 0, 1, 0, 0});  // SYNC
        vq.push_back('{0, 0, DZ, DZ, 1, 0, 1, 0});
        vq.push_back('{0, 0, DZ, DZ, 0, 0, 1, 0});
        vq.push_back('{0, 1, CN, DZ, 0, 0, 1, 0});  // wrong comma 1
        vq.push_back('{0, 1, CN, DZ, 0, 0, 1, 0});  // 2
        vq.push_back('{0, 1, CN, DZ, 0, 0, 1, 0});  // 3
        vq.push_back('{0, 1, CN, DZ, 0, 0, 1, 0});  // 4 -> LOS
        vq.push_back('{0, 0, DZ, DZ, 0, 0, 0, RL1});
        vq.push_back('{0, 0, DZ, DZ, 0, 0, 0, RL1});

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].r, vq[i].v, vq[i].u, vq[i].l);
            chk($sformatf("vec%0d align", i), align_event, vq[i].e_align);
            chk($sformatf("vec%0d prefer", i), prefer_upper_first, vq[i].e_prefer);
            chk($sformatf("vec%0d locked", i), locked, vq[i].e_locked);
            chk($sformatf("vec%0d relock", i), relock_cnt, vq[i].e_relock);
        end

        // Error count is cleared by GOOD_COMMAS correct commas.
        lock_lower("errclr");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, CN, DZ);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, DA, CP);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, CN, DZ);
        idle(2);
        chk("errclr still locked", locked, 1);
        chk("errclr relock", relock_cnt, 0);
        step(1'b0, 1'b1, CN, DZ);  // fourth error since the clear
        chk("errclr lag", locked, 1);
        idle(1);
        chk("errclr lost", locked, 0);
        chk("errclr relock after", relock_cnt, RL1);

        // Comma starvation window.
        lock_lower("win");
        for (int i = 0; i < 63; i++) step(1'b0, 1'b1, DA, DZ);
        idle(1);
        chk("win 63 locked", locked, 1);
        step(1'b0, 1'b1, DA, CP);
        for (int i = 0; i < 63; i++) step(1'b0, 1'b1, DA, DZ);
        idle(1);
        chk("win rearm locked", locked, 1);
        step(1'b0, 1'b1, DA, DZ);  // 64th word without a comma
        chk("win 64 lag", locked, 1);
        idle(1);
        chk("win 64 lost", locked, 0);
        chk("win relock", relock_cnt, RL1);

        // Candidate switch during ACQ.
        step(1'b1, 1'b0, DZ, DZ);
        step(1'b0, 1'b1, CN, DZ);
        step(1'b0, 1'b1, CN, DZ);
        step(1'b0, 1'b1, DA, CP);
        step(1'b0, 1'b1, DA, CP);
        chk("switch 4th locked", locked, 0);
        step(1'b0, 1'b1, DA, CP);
        chk("switch 5th align", align_event, 0);
        chk("switch 5th locked", locked, 0);
        idle(1);
        chk("switch align", align_event, 1);
        chk("switch prefer", prefer_upper_first, 0);
        chk("switch locked", locked, 1);
        idle(1);
        chk("switch align end", align_event, 0);

        // Reset during ACQ, with a simultaneous valid word.
        step(1'b1, 1'b0, DZ, DZ);
        step(1'b0, 1'b1, CN, DZ);
        step(1'b0, 1'b1, CN, DZ);
        step(1'b1, 1'b1, CN, DZ);
        step(1'b0, 1'b1, CN, DZ);
        idle(3);
        chk("rstacq align", align_event, 0);
        chk("rstacq locked", locked, 0);

        // Reset drops a pending acquisition pulse.
        step(1'b1, 1'b0, DZ, DZ);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, CN, DZ);
        step(1'b1, 1'b0, DZ, DZ);
        chk("rstpulse align", align_event, 0);
        chk("rstpulse locked", locked, 0);
        idle(1);
        chk("rstpulse align2", align_event, 0);

        // Both halves carry a comma: upper wins on re-acquisition.
        lock_lower("both");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, CN, DZ);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, CP, CN);
        idle(1);
        chk("both align", align_event, 1);
        chk("both prefer", prefer_upper_first, 1);
        chk("both locked", locked, 1);
        chk("both relock", relock_cnt, RL1);

        // ACQ_COMMAS=1 locks on a single comma.
        step(1'b1, 1'b0, DZ, DZ);
        step(1'b0, 1'b1, DA, CP);
        chk("acq1 lag", align1, 0);
        idle(1);
        chk("acq1 align", align1, 1);
        chk("acq1 prefer", prefer1, 0);
        chk("acq1 locked", locked1, 1);
        chk("acq1 main locked", locked, 0);
        idle(1);
        chk("acq1 align end", align1, 0);
        chk("acq1 relock", relock1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
